mmio_timer_core: RTL and testbench

Memory-mapped timer slot that responds to the MMIO slot bus driven by the MCS bridge through `mmio_sys`. It holds a free-running W-bit up-counter with go/clear control, a W-bit compare register, a sticky match flag and a level interrupt output. It occupies one slot of `mmio_sys` alongside the switch, LED and UART cores, and gives firmware timestamps and periodic events.

---
 rtl/mmio_timer_pkg.sv | 22 ++
 rtl/timer_counter.sv | 38 +++
 rtl/mmio_timer_core.sv | 118 +++++++++++
 tb/tb_mmio_timer_core.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared constants for the MMIO timer slot:
// register indices, CTRL bit positions, compare reset value.
package mmio_timer_pkg;

    localparam int unsigned TMR_CTRL   = 0;
    localparam int unsigned TMR_CNT_LO = 1;
    localparam int unsigned TMR_CNT_HI = 2;
    localparam int unsigned TMR_CMP_LO = 3;
    localparam int unsigned TMR_CMP_HI = 4;
    localparam int unsigned TMR_STATUS = 5;

    localparam int CTRL_GO     = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_RELOAD = 2;
    localparam int CTRL_IRQEN  = 3;

    localparam int STAT_MATCH  = 0;

    // Widest legal compare register, sliced down to W at use.
    localparam logic [63:0] CMP_RST = '1;

endpackage

// File: rtl/timer_counter.sv
// W-bit up-counter with clear, auto-reload and enable,
// plus the equality compare that produces match.
module timer_counter
    import mmio_timer_pkg::*;
#(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_go,
    input  logic         i_clr,
    input  logic         i_reload,
    input  logic [W-1:0] i_cmp,
    output logic [W-1:0] o_count,
    output logic         o_match
);

    logic [W-1:0] r_count;
    logic         w_eq;

    assign w_eq    = (r_count == i_cmp);
    assign o_match = i_go & w_eq;
    assign o_count = r_count;

    // Clear beats reload beats increment; no branch means hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (o_match && i_reload) begin
            r_count <= '0;
        end else if (i_go) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_timer_core.sv
// MMIO timer slot: register file, count snapshot,
// sticky match flag, level irq and combinational read mux.
module mmio_timer_core
    import mmio_timer_pkg::*;
#(
    parameter int W      = 48,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              irq
);

    logic          r_go;
    logic          r_reload;
    logic          r_irq_en;
    logic          r_flag;
    logic [W-1:0]  r_cmp;
    logic [W-33:0] r_snap;

    logic [W-1:0]  w_count;
    logic          w_match;
    logic          w_wr;
    logic          w_wr_ctrl;
    logic          w_wr_cmp_lo;
    logic          w_wr_cmp_hi;
    logic          w_wr_stat;
    logic          w_clr;
    logic          w_snap;

    assign w_wr        = cs & write;
    assign w_wr_ctrl   = w_wr && (addr == ADDR_W'(TMR_CTRL));
    assign w_wr_cmp_lo = w_wr && (addr == ADDR_W'(TMR_CMP_LO));
    assign w_wr_cmp_hi = w_wr && (addr == ADDR_W'(TMR_CMP_HI));
    assign w_wr_stat   = w_wr && (addr == ADDR_W'(TMR_STATUS));
    assign w_clr       = w_wr_ctrl & wr_data[CTRL_CLR];
    assign w_snap      = cs & read & (addr == ADDR_W'(TMR_CNT_LO));

    timer_counter #(
        .W (W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .i_go     (r_go),
        .i_clr    (w_clr),
        .i_reload (r_reload),
        .i_cmp    (r_cmp),
        .o_count  (w_count),
        .o_match  (w_match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_go     <= 1'b0;
            r_reload <= 1'b0;
            r_irq_en <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_go     <= wr_data[CTRL_GO];
            r_reload <= wr_data[CTRL_RELOAD];
            r_irq_en <= wr_data[CTRL_IRQEN];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmp <= CMP_RST[W-1:0];
        end else begin
            if (w_wr_cmp_lo) r_cmp[31:0]  <= wr_data;
            if (w_wr_cmp_hi) r_cmp[W-1:32] <= wr_data[W-33:0];
        end
    end

    // Upper half frozen by a CNT_LO read so a LO/HI pair is coherent.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap <= '0;
        end else if (w_snap) begin
            r_snap <= w_count[W-1:32];
        end
    end

    // A new match outranks a software clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flag <= 1'b0;
        end else if (w_match) begin
            r_flag <= 1'b1;
        end else if (w_wr_stat && wr_data[STAT_MATCH]) begin
            r_flag <= 1'b0;
        end
    end

    assign irq = r_flag & r_irq_en;

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_W'(TMR_CTRL): begin
                rd_data[CTRL_GO]     = r_go;
                rd_data[CTRL_RELOAD] = r_reload;
                rd_data[CTRL_IRQEN]  = r_irq_en;
            end
            ADDR_W'(TMR_CNT_LO): rd_data = w_count[31:0];
            ADDR_W'(TMR_CNT_HI): rd_data[W-33:0] = r_snap;
            ADDR_W'(TMR_CMP_LO): rd_data = r_cmp[31:0];
            ADDR_W'(TMR_CMP_HI): rd_data[W-33:0] = r_cmp[W-1:32];
            ADDR_W'(TMR_STATUS): rd_data[STAT_MATCH] = r_flag;
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_mmio_timer_core.sv
// Directed bench for mmio_timer_core (W=48): bus accesses
// start and end on a falling edge, one cycle each.
module tb_mmio_timer_core;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        irq;

    int n_vec;
    int n_err;

    logic [31:0] d;
    logic [31:0] d2;

    mmio_timer_core #(
        .W      (48),
        .ADDR_W (5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h",
                     tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [4:0] a,
                          input logic [31:0] v);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = v;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; wr_data = '0;
    endtask

    task automatic bus_rd(input logic [4:0] a,
                          output logic [31:0] v);
        cs = 1'b1; read = 1'b1; addr = a;
        #1 v = rd_data;
        @(negedge clk);
        cs = 1'b0; read = 1'b0;
    endtask

    // Look at rd_data with no strobe, so no snapshot side effect.
    task automatic peek(input logic [4:0] a,
                        output logic [31:0] v);
        addr = a;
        #1 v = rd_data;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; wr_data = '0;
        idle(2);
        reset = 1'b0;

        // Reset values
        bus_rd(5'd0, d); check("rst_ctrl", d, 32'h0);
        bus_rd(5'd1, d); check("rst_cnt_lo", d, 32'h0);
        bus_rd(5'd2, d); check("rst_cnt_hi", d, 32'h0);
        bus_rd(5'd3, d); check("rst_cmp_lo", d, 32'hFFFF_FFFF);
        bus_rd(5'd4, d); check("rst_cmp_hi", d, 32'h0000_FFFF);
        bus_rd(5'd5, d); check("rst_status", d, 32'h0);
        bus_rd(5'd7, d); check("rst_unmapped", d, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);

        // Free run 100 cycles, then freeze
        bus_wr(5'd0, 32'h1);
        idle(100);
        bus_rd(5'd1, d); check("run_cnt_lo", d, 32'd100);
        bus_rd(5'd2, d); check("run_cnt_hi", d, 32'd0);
        bus_wr(5'd0, 32'h0);
        bus_rd(5'd1, d); check("stop_cnt_a", d, 32'd103);
        idle(10);
        bus_rd(5'd1, d2); check("stop_cnt_b", d2, 32'd103);
        bus_rd(5'd0, d); check("stop_ctrl", d, 32'h0);

        // Auto-reload with cmp=9, irq and flag clear
        bus_wr(5'd3, 32'd9);
        bus_wr(5'd4, 32'd0);
        bus_wr(5'd0, 32'h2);
        bus_rd(5'd1, d); check("clr_only", d, 32'd0);
        bus_wr(5'd0, 32'hD);
        idle(9);
        peek(5'd1, d); check("ar_cnt9", d, 32'd9);
        check("ar_irq_pre", {31'b0, irq}, 32'h0);
        idle(1);
        peek(5'd1, d); check("ar_wrap0", d, 32'd0);
        check("ar_irq_rise", {31'b0, irq}, 32'h1);
        idle(9);
        peek(5'd1, d); check("ar_cnt9_b", d, 32'd9);
        idle(1);
        peek(5'd1, d); check("ar_wrap0_b", d, 32'd0);
        check("ar_irq_hold", {31'b0, irq}, 32'h1);
        bus_wr(5'd5, 32'h1);
        check("st_clr_irq", {31'b0, irq}, 32'h0);
        peek(5'd5, d); check("st_clr_flag", d, 32'h0);
        idle(8);
        peek(5'd1, d); check("ar_cnt9_c", d, 32'd9);
        bus_wr(5'd5, 32'h1);
        check("st_clr_vs_match", {31'b0, irq}, 32'h1);
        peek(5'd5, d); check("st_set_wins", d, 32'h1);

        // go + clear while running at 500
        bus_wr(5'd3, 32'hFFFF_FFFF);
        bus_wr(5'd4, 32'h0000_FFFF);
        bus_wr(5'd0, 32'h3);
        idle(500);
        peek(5'd1, d); check("gc_cnt500", d, 32'd500);
        bus_wr(5'd0, 32'h3);
        peek(5'd1, d); check("gc_cnt0", d, 32'd0);
        idle(1);
        peek(5'd1, d); check("gc_cnt1", d, 32'd1);
        bus_rd(5'd0, d); check("gc_ctrl", d, 32'h1);
        check("gc_irq_off", {31'b0, irq}, 32'h0);

        // Carry into bit 32 and snapshot coherence
        bus_wr(5'd0, 32'h0);
        force dut.u_cnt.r_count = 48'h0000_FFFF_FFFE;
        idle(1);
        release dut.u_cnt.r_count;
        idle(1);
        bus_rd(5'd1, d); check("cy_lo_pre", d, 32'hFFFF_FFFE);
        bus_rd(5'd2, d); check("cy_hi_pre", d, 32'h0);
        bus_wr(5'd0, 32'h1);
        idle(2);
        bus_rd(5'd1, d); check("cy_lo_post", d, 32'h0);
        bus_rd(5'd2, d); check("cy_hi_post", d, 32'h1);

        // Reset mid-count with flag set
        bus_wr(5'd0, 32'h9);
        check("pre_rst_irq", {31'b0, irq}, 32'h1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        bus_rd(5'd0, d); check("mid_rst_ctrl", d, 32'h0);
        bus_rd(5'd1, d); check("mid_rst_cnt", d, 32'h0);
        bus_rd(5'd2, d); check("mid_rst_hi", d, 32'h0);
        bus_rd(5'd3, d); check("mid_rst_cmp_lo", d, 32'hFFFF_FFFF);
        bus_rd(5'd4, d); check("mid_rst_cmp_hi", d, 32'h0000_FFFF);
        bus_rd(5'd5, d); check("mid_rst_stat", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
